// File: rtl/mat3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mat3_seq_ctrl
// Sequencing controller for a 3x3 byte matrix multiplier built around one
// time-shared 8x8 multiply-accumulate unit.
//   LOAD    : collect 18 operand bytes (A row-major, then B row-major) from the
//             UART receiver; a stalled partial load is discarded after
//             RX_TIMEOUT idle cycles.
//   COMPUTE : 27 MAC cycles produce the nine 18-bit results of R = A*B.
//   SEND    : each result goes out as 3 big-endian bytes; one tx_start per byte.
//   GAP     : GAP_CYCLES idle cycles between a tx_done and the next tx_start.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx_data[7:0] received byte, qualified by rx_valid
//   rx_valid     one-cycle pulse per received byte
//   tx_done      one-cycle pulse when the transmitter finishes a byte
//   tx_data[7:0] byte to transmit, stable from tx_start until tx_done
//   tx_start     one-cycle transmit request
//   busy         high while computing or sending
//   load_count   operand bytes accepted so far (0..18)
//   display      last accepted operand byte
//   done         one-cycle pulse after the final byte's tx_done
//   err_timeout  one-cycle pulse when a partial load is discarded
// -----------------------------------------------------------------------------
module mat3_seq_ctrl #(
  parameter int unsigned CLOCK_RATE = 100_000_000,
  parameter int unsigned GAP_CYCLES = 12_500,
  parameter int unsigned RX_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic [4:0] load_count,
  output logic [7:0] display,
  output logic       done,
  output logic       err_timeout
);

  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(RX_TIMEOUT + 1);

  // Counters below assume at least one cycle of gap and of timeout.
  if (GAP_CYCLES < 1 || RX_TIMEOUT < 1 || CLOCK_RATE < 1) begin : g_param_check
    $error("mat3_seq_ctrl: GAP_CYCLES, RX_TIMEOUT and CLOCK_RATE must be >= 1");
  end

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_SEND, ST_GAP} state_t;

  state_t state, state_nxt;

  // Operand storage: A in [0..8], B in [9..17]. Results R[0..8].
  logic [7:0]  op_mem  [0:17];
  logic [17:0] res_mem [0:8];

  logic [IDLE_W-1:0] idle_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [1:0]        row, col, kk;     // result row/column and inner term
  logic [17:0]       acc;
  logic [3:0]        res_idx;          // result being transmitted
  logic [1:0]        byte_sel;         // 0 = MSB byte, 2 = LSB byte

  // MAC datapath
  logic [4:0]  a_idx, b_idx;
  logic [3:0]  r_idx;
  logic [15:0] prod;
  logic [17:0] acc_nxt;
  logic        compute_last;
  logic        send_last;
  logic        gap_last;
  logic [17:0] res_word;
  logic [7:0]  tx_byte;

  always_comb begin
    a_idx        = {3'b0, row} * 5'd3 + {3'b0, kk};
    b_idx        = 5'd9 + {3'b0, kk} * 5'd3 + {3'b0, col};
    r_idx        = {2'b0, row} * 4'd3 + {2'b0, col};
    prod         = {8'b0, op_mem[a_idx]} * {8'b0, op_mem[b_idx]};
    acc_nxt      = (kk == 2'd0) ? {2'b0, prod} : acc + {2'b0, prod};
    compute_last = (row == 2'd2) && (col == 2'd2) && (kk == 2'd2);
    send_last    = (res_idx == 4'd8) && (byte_sel == 2'd2);
    gap_last     = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  end

  // Byte of the current result selected for transmission, big-endian.
  always_comb begin
    res_word = res_mem[res_idx];
    unique case (byte_sel)
      2'd0:    tx_byte = {6'b0, res_word[17:16]};
      2'd1:    tx_byte = res_word[15:8];
      default: tx_byte = res_word[7:0];
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD:    if (rx_valid && load_count == 5'd17) state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (compute_last)                   state_nxt = ST_SEND;
      ST_SEND:    if (tx_done)                        state_nxt = send_last ? ST_LOAD : ST_GAP;
      ST_GAP:     if (gap_last)                       state_nxt = ST_SEND;
      default:                                        state_nxt = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state != ST_LOAD);
  end

  // ---------------------------------------------------------------------------
  // Control counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count  <= 5'd0;
      display     <= 8'd0;
      idle_cnt    <= '0;
      gap_cnt     <= '0;
      row         <= 2'd0;
      col         <= 2'd0;
      kk          <= 2'd0;
      acc         <= 18'd0;
      res_idx     <= 4'd0;
      byte_sel    <= 2'd0;
      tx_data     <= 8'd0;
      tx_start    <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          // An arriving byte always wins over a timeout in the same cycle.
          if (rx_valid) begin
            load_count <= load_count + 5'd1;
            display    <= rx_data;
            idle_cnt   <= '0;
          end else if (load_count != 5'd0) begin
            if (idle_cnt == IDLE_W'(RX_TIMEOUT - 1)) begin
              load_count  <= 5'd0;
              err_timeout <= 1'b1;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          acc <= acc_nxt;
          if (kk == 2'd2) begin
            kk <= 2'd0;
            if (col == 2'd2) begin
              col <= 2'd0;
              row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
            end else begin
              col <= col + 2'd1;
            end
          end else begin
            kk <= kk + 2'd1;
          end
          // R[0] is already stored, so the first byte can be presented
          // on the same edge that writes R[8].
          if (compute_last) begin
            tx_data  <= tx_byte;
            tx_start <= 1'b1;
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            if (send_last) begin
              done       <= 1'b1;
              load_count <= 5'd0;
              res_idx    <= 4'd0;
              byte_sel   <= 2'd0;
            end else begin
              gap_cnt <= '0;
              if (byte_sel == 2'd2) begin
                byte_sel <= 2'd0;
                res_idx  <= res_idx + 4'd1;
              end else begin
                byte_sel <= byte_sel + 2'd1;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_last) begin
            tx_data  <= tx_byte;
            tx_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand and result storage
  // ---------------------------------------------------------------------------
  // NOTE: the arrays have no reset: every entry is written before it is read,
  // and leaving them out of reset lets them map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && rx_valid && !rst)
      op_mem[load_count] <= rx_data;
    if (state == ST_COMPUTE && kk == 2'd2 && !rst)
      res_mem[r_idx] <= acc_nxt;
  end

endmodule

// File: tb/tb_mat3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mat3_seq_ctrl
// Self-checking bench for mat3_seq_ctrl. A reference model computes R = A*B
// with integer arithmetic and expands it into the expected 27-byte stream;
// a small transmitter model answers each tx_start with tx_done after a random
// delay. Latencies, gap timing, timeout handling and reset abort are checked.
// -----------------------------------------------------------------------------
module tb_mat3_seq_ctrl;

  localparam int GAP = 10;
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic [4:0] load_count;
  logic [7:0] display;
  logic       done;
  logic       err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mat3_seq_ctrl #(
    .CLOCK_RATE (100_000_000),
    .GAP_CYCLES (GAP),
    .RX_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_done     (tx_done),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .load_count  (load_count),
    .display     (display),
    .done        (done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_load_count"}, load_count, 0);
    check({tag, "_display"}, display, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  // Full transaction: load A and B, follow the result stream, compare with
  // the model. inject adds stray rx_valid/tx_done pulses while busy.
  // abort_after > 0 asserts rst right after that many tx_done pulses.
  task automatic run_matrix(input logic [7:0] a [9], input logic [7:0] b [9],
                            input bit inject, input int abort_after);
    logic [7:0] exp_q [$];
    int r, c18, tstart, tdone, waited, hold, seen;
    logic [7:0] d;

    exp_q = {};
    for (int i = 0; i < 9; i++) begin
      r = 0;
      for (int k = 0; k < 3; k++)
        r += int'(a[3*(i/3)+k]) * int'(b[3*k+(i%3)]);
      exp_q.push_back(8'((r >> 16) & 255));
      exp_q.push_back(8'((r >> 8) & 255));
      exp_q.push_back(8'(r & 255));
    end

    c18 = 0;
    for (int n = 0; n < 18; n++) begin
      d = (n < 9) ? a[n] : b[n-9];
      rx_data  = d;
      rx_valid = 1'b1;
      if (n == 17) c18 = cyc;
      tick();
      rx_valid = 1'b0;
      check("load_count", load_count, n + 1);
      check("display", display, d);
      if (n < 17) repeat ($urandom_range(0, 3)) tick();
    end
    check("busy_after_load", busy, 1);

    tdone = 0;
    for (int bi = 0; bi < 27; bi++) begin
      waited = 0;
      while (!tx_start && waited < 100) begin
        if (inject) begin
          rx_valid = 1'($urandom_range(0, 1));
          rx_data  = 8'($urandom);
          if (bi > 0) tx_done = 1'($urandom_range(0, 1));
        end
        tick();
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        waited++;
      end
      if (!tx_start) begin
        check("tx_start_seen", 0, 1);
        return;
      end
      tstart = cyc;
      if (bi == 0) check("first_start_latency", tstart - c18, 28);
      else         check("gap_latency", tstart - tdone, GAP + 1);
      check("tx_data", tx_data, exp_q[bi]);

      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        if (inject) begin
          rx_valid = 1'($urandom_range(0, 1));
          rx_data  = 8'($urandom);
        end
        tick();
        rx_valid = 1'b0;
        check("tx_start_pulse", tx_start, 0);
        check("tx_data_hold", tx_data, exp_q[bi]);
      end

      tx_done = 1'b1;
      tdone   = cyc;
      tick();
      tx_done = 1'b0;
      if (bi == 26) begin
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("load_count_at_done", load_count, 0);
        tick();
        check("done_single", done, 0);
      end else begin
        check("done_early", done, 0);
        check("busy_in_gap", busy, 1);
        check("load_count_busy", load_count, 18);
      end

      if (abort_after == bi + 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("abort");
        seen = 0;
        for (int w = 0; w < 4 * GAP; w++) begin
          tick();
          if (tx_start || busy) seen++;
        end
        check("no_tx_after_rst", seen, 0);
        return;
      end
    end
  endtask

  // Partial load abandoned: 5 bytes, then TMO idle cycles.
  task automatic timeout_test();
    for (int n = 0; n < 5; n++) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
    end
    repeat (TMO - 1) tick();
    check("tmo_before_count", load_count, 5);
    check("tmo_before_err", err_timeout, 0);
    tick();
    check("tmo_err", err_timeout, 1);
    check("tmo_count", load_count, 0);
    tick();
    check("tmo_err_single", err_timeout, 0);
  endtask

  // A byte arriving in the timeout cycle cancels the timeout.
  task automatic timeout_cancel_test();
    for (int n = 0; n < 3; n++) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
    end
    repeat (TMO - 1) tick();
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("cancel_err", err_timeout, 0);
    check("cancel_count", load_count, 4);
    check("cancel_display", display, 8'h5A);
    repeat (TMO) tick();
    check("cancel_late_err", err_timeout, 1);
    check("cancel_late_count", load_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a [9];
    logic [7:0] b [9];

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    tx_done  = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Identity times 1..9
    for (int i = 0; i < 9; i++) begin
      a[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
      b[i] = 8'(i + 1);
    end
    run_matrix(a, b, 1'b0, 0);

    // All 0xFF: maximum result, no overflow
    for (int i = 0; i < 9; i++) begin
      a[i] = 8'hFF;
      b[i] = 8'hFF;
    end
    run_matrix(a, b, 1'b0, 0);

    // 1..9 times 9..1
    for (int i = 0; i < 9; i++) begin
      a[i] = 8'(i + 1);
      b[i] = 8'(9 - i);
    end
    run_matrix(a, b, 1'b0, 0);

    timeout_test();
    timeout_cancel_test();

    // Random loads, with stray pulses while busy
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 9; i++) begin
        a[i] = 8'($urandom);
        b[i] = 8'($urandom);
      end
      run_matrix(a, b, t != 0, 0);
    end

    // Reset after the 4th tx_done, then a clean run
    for (int i = 0; i < 9; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
    end
    run_matrix(a, b, 1'b0, 4);
    for (int i = 0; i < 9; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
    end
    run_matrix(a, b, 1'b1, 0);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
